counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter.sv | 21 ++
 tb/tb_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// counter: free-running WIDTH-bit up counter with count enable.
// Ports: clk, reset (async, active-low), enable (active-high), count (registered).
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Carry out of the top bit is dropped, so the count wraps to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for counter at WIDTH=4 and WIDTH=8.
// Stimulus pushes expected values; a monitor pops and compares each cycle.
module tb_counter;

    typedef struct {
        int e4;
        int e8;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] count4;
    logic [7:0] count8;

    exp_t q[$];
    int   m4;
    int   m8;
    int   checks;
    int   errors;

    counter dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count4)
    );

    counter #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a count that adds one per enabled edge, modulo 2^W.
    task automatic step(input logic e);
        exp_t x;
        @(negedge clk);
        enable = e;
        if (e) begin
            m4 = (m4 + 1) % 16;
            m8 = (m8 + 1) % 256;
        end
        x.e4 = m4;
        x.e8 = m8;
        q.push_back(x);
    endtask

    // Pull reset low between edges, confirm immediate clear and hold, release.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        m4 = 0;
        m8 = 0;
        #1;
        chk("async_clear4", 32'(count4), 0);
        chk("async_clear8", 32'(count8), 0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold4", 32'(count4), 0);
        chk("reset_hold8", 32'(count8), 0);
        @(negedge clk);
        enable = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("count4", 32'(count4), x.e4);
                chk("count8", 32'(count8), x.e8);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m4 = 0;
        m8 = 0;
        enable = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        chk("por4_before_edge", 32'(count4), 0);
        chk("por8_before_edge", 32'(count8), 0);
        #8;
        chk("por4_after", 32'(count4), 0);
        chk("por8_after", 32'(count8), 0);
        @(negedge clk);
        reset = 1'b1;

        // Count run to 10, hold two edges, then four more to 14.
        repeat (10) step(1'b1);
        repeat (2) step(1'b0);
        repeat (4) step(1'b1);
        @(posedge clk);
        #1;
        chk("run_hold_end", 32'(count4), 14);

        // Wrap from zero: 17 edges at WIDTH=4.
        async_reset();
        repeat (16) step(1'b1);
        @(posedge clk);
        #1;
        chk("wrap16", 32'(count4), 0);
        step(1'b1);
        @(posedge clk);
        #1;
        chk("wrap17", 32'(count4), 1);

        // Full 256-edge cycle at WIDTH=8.
        async_reset();
        repeat (256) step(1'b1);
        @(posedge clk);
        #1;
        chk("wrap256", 32'(count8), 0);

        // Reset from 7 mid-run.
        async_reset();
        repeat (7) step(1'b1);
        @(posedge clk);
        #1;
        chk("pre_reset7", 32'(count4), 7);
        async_reset();
        step(1'b1);

        // Random enable with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
